// File: rtl/spi_master_ram_if.sv
// SPI master for the SPI-slave RAM block: serialises one RAM command per request
// and, on read-data frames, captures the 8-bit MISO reply.
module spi_master_ram_if #(
    parameter int unsigned RD_WAIT    = 1,
    parameter int unsigned GAP_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd,
    input  logic [7:0] cmd_data,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       err,
    output logic       busy,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO
);

    localparam int unsigned CNT_W      = 4;
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(9);
    localparam logic [CNT_W-1:0] RECV_LAST  = CNT_W'(7);
    localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((RD_WAIT > 0) ? (RD_WAIT - 1) : 0);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [1:0]       CMD_RD_ADDR = 2'b10;
    localparam logic [1:0]       CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SEL,
        S_SHIFT,
        S_WAIT,
        S_RECV,
        S_GAP
    } state_t;

    state_t             r_state, w_state;
    logic [CNT_W-1:0]   r_cnt, w_cnt;
    logic [9:0]         r_frame, w_frame;
    logic [1:0]         r_cmd, w_cmd;
    logic [7:0]         r_rx, w_rx;
    logic               r_rd_addr_seen, w_rd_addr_seen;
    logic               r_ss_n, w_ss_n;
    logic               r_mosi, w_mosi;
    logic [7:0]         r_rd_data, w_rd_data;
    logic               r_rd_valid, w_rd_valid;
    logic               r_err, w_err;

    // Outputs are computed for the state being entered, so they line up with it.
    always_comb begin
        w_state        = r_state;
        w_cnt          = r_cnt;
        w_frame        = r_frame;
        w_cmd          = r_cmd;
        w_rx           = r_rx;
        w_rd_addr_seen = r_rd_addr_seen;
        w_ss_n         = r_ss_n;
        w_mosi         = 1'b0;
        w_rd_data      = r_rd_data;
        w_rd_valid     = 1'b0;
        w_err          = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_state = S_SETUP;
                    w_cmd   = cmd;
                    w_frame = {cmd, cmd_data};
                    w_ss_n  = 1'b0;
                    w_cnt   = '0;
                    if (cmd == CMD_RD_ADDR) begin
                        w_rd_addr_seen = 1'b1;
                    end
                    if (cmd == CMD_RD_DATA) begin
                        w_rd_addr_seen = 1'b0;
                        w_err          = ~r_rd_addr_seen;
                    end
                end
            end
            S_SETUP: begin
                w_state = S_SEL;
                w_mosi  = r_frame[9];
            end
            S_SEL: begin
                w_state = S_SHIFT;
                w_cnt   = '0;
                w_mosi  = r_frame[9];
            end
            // r_frame[9] is on the wire; shift so the next bit sits at [9]
            S_SHIFT: begin
                if (r_cnt == SHIFT_LAST) begin
                    w_cnt = '0;
                    if (r_cmd == CMD_RD_DATA) begin
                        w_state = (RD_WAIT == 0) ? S_RECV : S_WAIT;
                    end else begin
                        w_state = S_GAP;
                        w_ss_n  = 1'b1;
                    end
                end else begin
                    w_cnt   = r_cnt + CNT_W'(1);
                    w_mosi  = r_frame[8];
                    w_frame = {r_frame[8:0], 1'b0};
                end
            end
            S_WAIT: begin
                if (r_cnt == WAIT_LAST) begin
                    w_state = S_RECV;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_RECV: begin
                w_rx = {r_rx[6:0], MISO};
                if (r_cnt == RECV_LAST) begin
                    w_state    = S_GAP;
                    w_cnt      = '0;
                    w_ss_n     = 1'b1;
                    w_rd_data  = {r_rx[6:0], MISO};
                    w_rd_valid = 1'b1;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state = S_IDLE;
                    w_cnt   = '0;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state = S_IDLE;
                w_ss_n  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_frame        <= '0;
            r_cmd          <= '0;
            r_rx           <= '0;
            r_rd_addr_seen <= 1'b0;
            r_ss_n         <= 1'b1;
            r_mosi         <= 1'b0;
            r_rd_data      <= '0;
            r_rd_valid     <= 1'b0;
            r_err          <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_cnt          <= w_cnt;
            r_frame        <= w_frame;
            r_cmd          <= w_cmd;
            r_rx           <= w_rx;
            r_rd_addr_seen <= w_rd_addr_seen;
            r_ss_n         <= w_ss_n;
            r_mosi         <= w_mosi;
            r_rd_data      <= w_rd_data;
            r_rd_valid     <= w_rd_valid;
            r_err          <= w_err;
        end
    end

    assign cmd_ready = (r_state == S_IDLE);
    assign busy      = (r_state != S_IDLE);
    assign SS_n      = r_ss_n;
    assign MOSI      = r_mosi;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign err       = r_err;

endmodule

// File: tb/tb_spi_master_ram_if.sv
// Directed bench for spi_master_ram_if: default build (RD_WAIT=1, GAP=1) as dut A,
// RD_WAIT=0 / GAP=3 build as dut B, each with a frame-position based slave model.
module tb_spi_master_ram_if;

    localparam int A_RW  = 1;
    localparam int A_GAP = 1;
    localparam int B_RW  = 0;
    localparam int B_GAP = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1;
    logic       a_valid = 1'b0, b_valid = 1'b0;
    logic [1:0] a_cmd = 2'b00, b_cmd = 2'b00;
    logic [7:0] a_data = 8'h00, b_data = 8'h00;
    logic       a_ready, a_rd_valid, a_err, a_busy, a_ss_n, a_mosi;
    logic       b_ready, b_rd_valid, b_err, b_busy, b_ss_n, b_mosi;
    logic [7:0] a_rd_data, b_rd_data;
    logic       a_miso = 1'b0, b_miso = 1'b0;
    logic [7:0] slave_byte = 8'hA5;

    int checks   = 0;
    int failures = 0;

    spi_master_ram_if #(.RD_WAIT(A_RW), .GAP_CYCLES(A_GAP)) u_dut_a (
        .clk(clk), .rst(rst), .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd(a_cmd), .cmd_data(a_data), .rd_data(a_rd_data), .rd_valid(a_rd_valid),
        .err(a_err), .busy(a_busy), .SS_n(a_ss_n), .MOSI(a_mosi), .MISO(a_miso)
    );

    spi_master_ram_if #(.RD_WAIT(B_RW), .GAP_CYCLES(B_GAP)) u_dut_b (
        .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd(b_cmd), .cmd_data(b_data), .rd_data(b_rd_data), .rd_valid(b_rd_valid),
        .err(b_err), .busy(b_busy), .SS_n(b_ss_n), .MOSI(b_mosi), .MISO(b_miso)
    );

    // Slave reply: byte MSB first over SS_n-low cycles 13+RW .. 20+RW of a frame
    int a_n = 0, b_n = 0;
    always @(negedge clk) begin
        if (a_ss_n === 1'b0) a_n = a_n + 1; else a_n = 0;
        if (a_n >= 13 + A_RW && a_n <= 20 + A_RW) a_miso = slave_byte[20 + A_RW - a_n];
        else a_miso = 1'b0;
        if (b_ss_n === 1'b0) b_n = b_n + 1; else b_n = 0;
        if (b_n >= 13 + B_RW && b_n <= 20 + B_RW) b_miso = slave_byte[20 + B_RW - b_n];
        else b_miso = 1'b0;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input bit sel, input logic [1:0] c, input logic [7:0] d);
        if (sel) begin b_valid = 1'b1; b_cmd = c; b_data = d; end
        else     begin a_valid = 1'b1; a_cmd = c; a_data = d; end
        @(negedge clk);
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    // Records one frame from its first cycle until cmd_ready returns (bounded)
    task automatic monitor_frame(input bit sel, output int low, output logic [31:0] mseq,
                                 output int rv_cnt, output int rv_cyc, output logic [7:0] rv_dat,
                                 output int err_cnt, output int err_cyc, output int rdy_cyc);
        logic ss, mo, rv, er, rdy;
        logic [7:0] rd;
        low = 0; mseq = '0; rv_cnt = 0; rv_cyc = 0; rv_dat = '0;
        err_cnt = 0; err_cyc = 0; rdy_cyc = 0;
        for (int c = 1; c <= 60; c++) begin
            ss  = sel ? b_ss_n     : a_ss_n;
            mo  = sel ? b_mosi     : a_mosi;
            rv  = sel ? b_rd_valid : a_rd_valid;
            er  = sel ? b_err      : a_err;
            rdy = sel ? b_ready    : a_ready;
            rd  = sel ? b_rd_data  : a_rd_data;
            if (rdy === 1'b1) begin
                rdy_cyc = c;
                break;
            end
            if (ss === 1'b0) begin low++; mseq = {mseq[30:0], mo}; end
            if (rv === 1'b1) begin rv_cnt++; rv_cyc = c; rv_dat = rd; end
            if (er === 1'b1) begin err_cnt++; err_cyc = c; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (a_ss_n !== 1'b1) begin failures++; $display("FAIL reset_ss_n: got %b expected 1", a_ss_n); end
        checks++; if (a_mosi !== 1'b0) begin failures++; $display("FAIL reset_mosi: got %b expected 0", a_mosi); end
        checks++; if (a_rd_data !== 8'h00) begin failures++; $display("FAIL reset_rd_data: got %h expected 00", a_rd_data); end
        checks++; if (a_rd_valid !== 1'b0 || a_err !== 1'b0) begin failures++; $display("FAIL reset_pulses: got rd_valid=%b err=%b expected 0/0", a_rd_valid, a_err); end
        checks++; if (a_ready !== 1'b1 || a_busy !== 1'b0) begin failures++; $display("FAIL reset_ready_busy: got %b/%b expected 1/0", a_ready, a_busy); end
        checks++; if (b_ss_n !== 1'b1 || b_ready !== 1'b1) begin failures++; $display("FAIL reset_b: got ss_n=%b ready=%b expected 1/1", b_ss_n, b_ready); end
        rst = 1'b0;
    endtask

    task automatic test_write();
        int low, rvc, rvy, ec, ey, ry;
        logic [31:0] ms;
        logic [7:0] rvd;
        issue(1'b0, 2'b00, 8'h3A);
        monitor_frame(1'b0, low, ms, rvc, rvy, rvd, ec, ey, ry);
        checks++; if (ms !== 32'h0000_003A) begin failures++; $display("FAIL write_mosi: got %h expected 0000003a", ms); end
        checks++; if (low != 12) begin failures++; $display("FAIL write_ss_low: got %0d expected 12", low); end
        checks++; if (ry != 14) begin failures++; $display("FAIL write_ready_cycle: got %0d expected 14", ry); end
        checks++; if (ec != 0 || rvc != 0) begin failures++; $display("FAIL write_pulses: got err=%0d rd_valid=%0d expected 0/0", ec, rvc); end
    endtask

    task automatic test_read();
        int low, rvc, rvy, ec, ey, ry;
        logic [31:0] ms;
        logic [7:0] rvd;
        issue(1'b0, 2'b10, 8'h3A);
        monitor_frame(1'b0, low, ms, rvc, rvy, rvd, ec, ey, ry);
        checks++; if (ms !== 32'h0000_063A) begin failures++; $display("FAIL rdaddr_mosi: got %h expected 0000063a", ms); end
        checks++; if (ec != 0 || ry != 14) begin failures++; $display("FAIL rdaddr_frame: got err=%0d ready=%0d expected 0/14", ec, ry); end
        issue(1'b0, 2'b11, 8'h00);
        monitor_frame(1'b0, low, ms, rvc, rvy, rvd, ec, ey, ry);
        checks++; if (low != 21) begin failures++; $display("FAIL rd_ss_low: got %0d expected 21", low); end
        checks++; if (rvc != 1 || rvy != 22) begin failures++; $display("FAIL rd_valid_pulse: got count=%0d cycle=%0d expected 1/22", rvc, rvy); end
        checks++; if (rvd !== 8'hA5) begin failures++; $display("FAIL rd_data: got %h expected a5", rvd); end
        checks++; if (ec != 0) begin failures++; $display("FAIL rd_err: got %0d expected 0", ec); end
        checks++; if (ry != 23) begin failures++; $display("FAIL rd_ready_cycle: got %0d expected 23", ry); end
        checks++; if (a_rd_data !== 8'hA5) begin failures++; $display("FAIL rd_data_hold: got %h expected a5", a_rd_data); end
    endtask

    task automatic test_err_after_reset();
        int low, rvc, rvy, ec, ey, ry;
        logic [31:0] ms;
        logic [7:0] rvd;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        issue(1'b0, 2'b11, 8'h00);
        monitor_frame(1'b0, low, ms, rvc, rvy, rvd, ec, ey, ry);
        checks++; if (ec != 1 || ey != 1) begin failures++; $display("FAIL err_pulse: got count=%0d cycle=%0d expected 1/1", ec, ey); end
        checks++; if (rvc != 1 || rvd !== 8'hA5) begin failures++; $display("FAIL err_frame_rd: got count=%0d data=%h expected 1/a5", rvc, rvd); end
        checks++; if (low != 21) begin failures++; $display("FAIL err_frame_len: got %0d expected 21", low); end
    endtask

    task automatic test_hold_valid();
        int low, rvc, rvy, ec, ey, ry;
        logic [31:0] ms;
        logic [7:0] rvd;
        a_valid = 1'b1; a_cmd = 2'b00; a_data = 8'h11;
        @(negedge clk);
        fork
            monitor_frame(1'b0, low, ms, rvc, rvy, rvd, ec, ey, ry);
            begin
                repeat (13) begin
                    @(posedge clk);
                    #1;
                    a_cmd  = 2'b01;
                    a_data = a_data + 8'h11;
                end
            end
        join
        checks++; if (ms !== 32'h0000_0011) begin failures++; $display("FAIL hold_first_mosi: got %h expected 00000011", ms); end
        checks++; if (ry != 14 || low != 12) begin failures++; $display("FAIL hold_first_frame: got ready=%0d low=%0d expected 14/12", ry, low); end
        @(negedge clk);
        a_valid = 1'b0;
        checks++; if (a_ss_n !== 1'b0 || a_ready !== 1'b0) begin failures++; $display("FAIL hold_accept: got ss_n=%b ready=%b expected 0/0", a_ss_n, a_ready); end
        monitor_frame(1'b0, low, ms, rvc, rvy, rvd, ec, ey, ry);
        checks++; if (ms !== 32'h0000_01EE) begin failures++; $display("FAIL hold_second_mosi: got %h expected 000001ee", ms); end
        checks++; if (ry != 14) begin failures++; $display("FAIL hold_second_ready: got %0d expected 14", ry); end
    endtask

    task automatic test_reset_mid_frame();
        int low, rvc, rvy, ec, ey, ry;
        logic [31:0] ms;
        logic [7:0] rvd;
        issue(1'b0, 2'b00, 8'hFF);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++; if (a_ss_n !== 1'b1 || a_mosi !== 1'b0) begin failures++; $display("FAIL midrst_lines: got ss_n=%b mosi=%b expected 1/0", a_ss_n, a_mosi); end
        checks++; if (a_ready !== 1'b1) begin failures++; $display("FAIL midrst_ready: got %b expected 1", a_ready); end
        rst = 1'b0;
        issue(1'b0, 2'b01, 8'hFF);
        monitor_frame(1'b0, low, ms, rvc, rvy, rvd, ec, ey, ry);
        checks++; if (ms !== 32'h0000_01FF) begin failures++; $display("FAIL midrst_next_mosi: got %h expected 000001ff", ms); end
        checks++; if (low != 12 || ry != 14) begin failures++; $display("FAIL midrst_next_frame: got low=%0d ready=%0d expected 12/14", low, ry); end
    endtask

    task automatic test_back_to_back_gap3();
        int low, rvc, rvy, ec, ey, ry;
        logic [31:0] ms;
        logic [7:0] rvd;
        issue(1'b1, 2'b00, 8'h3A);
        monitor_frame(1'b1, low, ms, rvc, rvy, rvd, ec, ey, ry);
        checks++; if (ms !== 32'h0000_003A || low != 12) begin failures++; $display("FAIL gap3_write: got mosi=%h low=%0d expected 0000003a/12", ms, low); end
        checks++; if (ry - low - 1 != B_GAP) begin failures++; $display("FAIL gap3_ss_high: got %0d expected %0d", ry - low - 1, B_GAP); end
        issue(1'b1, 2'b10, 8'h3A);
        monitor_frame(1'b1, low, ms, rvc, rvy, rvd, ec, ey, ry);
        checks++; if (ry != 16) begin failures++; $display("FAIL gap3_rdaddr_ready: got %0d expected 16", ry); end
        issue(1'b1, 2'b11, 8'h00);
        monitor_frame(1'b1, low, ms, rvc, rvy, rvd, ec, ey, ry);
        checks++; if (low != 20) begin failures++; $display("FAIL gap3_rd_low: got %0d expected 20", low); end
        checks++; if (rvc != 1 || rvy != 21 || rvd !== 8'hA5) begin failures++; $display("FAIL gap3_rd_data: got count=%0d cycle=%0d data=%h expected 1/21/a5", rvc, rvy, rvd); end
        checks++; if (ry != 24 || ec != 0) begin failures++; $display("FAIL gap3_rd_ready: got ready=%0d err=%0d expected 24/0", ry, ec); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_err_after_reset();
        test_hold_valid();
        test_reset_mid_frame();
        test_back_to_back_gap3();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/spi_master_ram_if.md
Name: spi_master_ram_if

Overview:
- SPI master that drives the team's SPI slave / single-port RAM block over SS_n, MOSI and MISO, clocked one bit per system clk.
- Takes RAM commands (write address, write data, read address, read data) from a local valid/ready request port and serialises each one as an SPI frame.
- On read-data frames it deserialises the slave's 8-bit MISO reply and returns it with a one-cycle valid pulse.
- Sits between the system controller and the SPI slave; used as the bench driver and the on-chip initiator.

Parameters:
- RD_WAIT, 1, SS_n-low cycles between the last MOSI bit and the first MISO sample on read-data frames (≥0).
- GAP_CYCLES, 1, SS_n-high cycles after each frame before a new command is accepted (≥1).

Ports:
- clk  in  1  system clock; also the SPI bit clock.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  request valid.
- cmd_ready  out  1  high iff state==IDLE.
- cmd  in  2  00 wr_addr, 01 wr_data, 10 rd_addr, 11 rd_data.
- cmd_data  in  8  payload; don't-care for 11, sent as-is.
- rd_data  out  8  last byte received on MISO.
- rd_valid  out  1  one-cycle pulse when rd_data is updated.
- err  out  1  one-cycle pulse on protocol-order violation.
- busy  out  1  high whenever state!=IDLE.
- SS_n  out  1  slave select, active-low.
- MOSI  out  1  serial data to slave, MSB first.
- MISO  in  1  serial data from slave.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, SS_n=1, MOSI=0, rd_data=0, rd_valid=0, err=0, rd_addr_seen=0.
  - Overrides any frame in progress; SS_n rises on the next edge with no partial-frame completion.
- All outputs are registered except cmd_ready and busy, which decode state.
- Accept: cmd_valid & cmd_ready at edge E latches cmd and cmd_data. cmd_valid while busy is ignored and not queued.
- States and per-cycle outputs (cycles counted after E):
  - SETUP, 1 cycle: SS_n=0, MOSI=0. The slave leaves idle.
  - SEL, 1 cycle: MOSI=cmd[1]. This is the slave's write/read selector.
  - SHIFT, 10 cycles: MOSI = cmd[1], cmd[0], cmd_data[7..0].
  - If cmd!=11, go to GAP.
  - If cmd==11: WAIT for RD_WAIT cycles (MOSI=0, SS_n=0), then RECV.
  - RECV, 8 cycles: MISO is sampled at the rising edge ending each cycle into a shift register, MSB first; SS_n=0.
  - GAP, GAP_CYCLES cycles: SS_n=1, MOSI=0, then IDLE.
- Frame lengths:
  - Write or rd_addr frame: SS_n low for exactly 12 cycles.
  - rd_data frame: SS_n low for 20+RD_WAIT cycles.
  - The next cmd_ready rises GAP_CYCLES cycles after SS_n rises.
- rd_data / rd_valid: updated with the full byte, and rd_valid=1, during the first GAP cycle of a rd_data frame only.
- Ordering tracker:
  - rd_addr_seen is set when a 10 frame is accepted and cleared when an 11 frame is accepted.
  - Accepting 11 with rd_addr_seen=0 pulses err for one cycle (the SETUP cycle). The frame still executes.
- Bit counter is 4 bits and reused across SHIFT, WAIT and RECV. It is reloaded on each state entry, so there is no wrap.
- Simultaneous events:
  - rst overrides cmd_valid.
  - A command presented in the last GAP cycle is not accepted, because cmd_ready=0 in GAP.

Test Plan:
- rst high 2 cycles, then low, cmd=00 data=0x3A valid 1 cycle → MOSI over SETUP..SHIFT = 0,0,0,0,0,0,1,1,1,0,1,0; SS_n low exactly 12 cycles; cmd_ready low for 13 cycles.
- Sequence 10/0x3A, then 11 with a slave model driving 0xA5 on MISO after RD_WAIT=1 → rd_data=0xA5 with a one-cycle rd_valid in the first GAP cycle; SS_n low 21 cycles; err stays 0.
- 11 issued directly after reset → err pulses in the SETUP cycle; frame completes; rd_valid still pulses.
- cmd_valid held high during a frame with changing cmd_data → only the first command is sent; the next is accepted exactly when cmd_ready returns.
- rst asserted in the 5th SHIFT cycle → next cycle SS_n=1, MOSI=0, cmd_ready=1; a following 01/0xFF frame is sent intact.
- GAP_CYCLES=3, RD_WAIT=0 build → SS_n high 3 cycles between back-to-back frames; rd_data frame SS_n low 20 cycles.
